// File: rtl/traffic_phase_scheduler.sv
// Four-approach junction phase sequencer: round-robin green grant with green/yellow/all-red timing.
// Define TRAFFIC_PHASE_SCHED_EMERG_EN to enable emergency latch, preemption and service.
module traffic_phase_scheduler #(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 32,
  parameter int unsigned YELLOW    = 4,
  parameter int unsigned ALLRED    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       emerg_valid,
  input  logic [1:0] emerg_board,
  output logic       emerg_busy,
  output logic       emerg_ack,
  output logic [1:0] board_sel,
  output logic [7:0] lamp
);

  typedef enum logic [1:0] {StAllred, StGreen, StYellow} state_e;

  localparam logic [CNT_W-1:0] AllredLast   = CNT_W'(ALLRED - 1);
  localparam logic [CNT_W-1:0] GreenMinLast = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GreenMaxLast = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW - 1);

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [1:0]       board_sel_q;
  logic [1:0]       last_q;
  logic [7:0]       lamp_q;

  logic       rr_valid;
  logic [1:0] rr_board;
  logic       cand_valid;
  logic [1:0] cand_board;
  logic       same_serve;
  logic       preempt;
  logic       enter_green;
  logic       leave_green;

  function automatic logic [7:0] lamp_of(logic [1:0] b, logic [1:0] code);
    logic [7:0] l;
    l = '0;
    l[2*b +: 2] = code;
    return l;
  endfunction

  // Round-robin search starting just after the last served board.
  always_comb begin
    logic [1:0] idx;
    rr_valid = 1'b0;
    rr_board = last_q;
    idx      = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!rr_valid && req[idx]) begin
        rr_valid = 1'b1;
        rr_board = idx;
      end
    end
  end

`ifdef TRAFFIC_PHASE_SCHED_EMERG_EN
  logic       busy_q;
  logic       ack_q;
  logic [1:0] emerg_board_q;

  assign cand_valid = busy_q | rr_valid;
  assign cand_board = busy_q ? emerg_board_q : rr_board;
  // An emergency for the board already green is served on the spot by restarting its green.
  assign same_serve = (state_q == StGreen) && emerg_valid && !busy_q &&
                      (emerg_board == board_sel_q);
  assign preempt    = busy_q && (emerg_board_q != board_sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      emerg_board_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (same_serve) begin
        ack_q <= 1'b1;
      end else if (busy_q && enter_green) begin
        busy_q <= 1'b0;
        ack_q  <= 1'b1;
      end else if (emerg_valid && !busy_q) begin
        busy_q        <= 1'b1;
        emerg_board_q <= emerg_board;
      end
    end
  end

  assign emerg_busy = busy_q;
  assign emerg_ack  = ack_q;
`else
  logic unused_emerg;
  assign unused_emerg = ^{emerg_valid, emerg_board};
  assign cand_valid   = rr_valid;
  assign cand_board   = rr_board;
  assign same_serve   = 1'b0;
  assign preempt      = 1'b0;
  assign emerg_busy   = 1'b0;
  assign emerg_ack    = 1'b0;
`endif

  assign enter_green = (state_q == StAllred) && (timer_q >= AllredLast) && cand_valid;
  assign leave_green = (timer_q == GreenMaxLast) || preempt ||
                       ((timer_q >= GreenMinLast) &&
                        |(req & ~(4'b0001 << board_sel_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAllred;
      timer_q     <= '0;
      board_sel_q <= '0;
      last_q      <= 2'd3;
      lamp_q      <= '0;
    end else begin
      unique case (state_q)
        StAllred: begin
          if (enter_green) begin
            state_q     <= StGreen;
            timer_q     <= '0;
            board_sel_q <= cand_board;
            last_q      <= cand_board;
            lamp_q      <= lamp_of(cand_board, 2'b10);
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StGreen: begin
          if (same_serve) begin
            timer_q <= '0;
          end else if (leave_green) begin
            state_q <= StYellow;
            timer_q <= '0;
            lamp_q  <= lamp_of(board_sel_q, 2'b01);
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StYellow: begin
          if (timer_q == YellowLast) begin
            state_q <= StAllred;
            timer_q <= '0;
            lamp_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= StAllred;
          timer_q <= '0;
          lamp_q  <= '0;
        end
      endcase
    end
  end

  assign board_sel = board_sel_q;
  assign lamp      = lamp_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default parameters.
// Emergency scenarios follow TRAFFIC_PHASE_SCHED_EMERG_EN; otherwise the tie-off behaviour is checked.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       emerg_valid = 1'b0;
  logic [1:0] emerg_board = '0;
  logic       emerg_busy;
  logic       emerg_ack;
  logic [1:0] board_sel;
  logic [7:0] lamp;

  int errors = 0;
  int checks = 0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .emerg_valid(emerg_valid),
    .emerg_board(emerg_board),
    .emerg_busy (emerg_busy),
    .emerg_ack  (emerg_ack),
    .board_sel  (board_sel),
    .lamp       (lamp)
  );

  always #5 clk = ~clk;

  // Leaves the bench 1ns after reset release, inside the first all-red cycle.
  task automatic reset_dut(input logic [3:0] r);
    rst_n       = 1'b0;
    req         = r;
    emerg_valid = 1'b0;
    emerg_board = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL reset_lamp got %h want 00", lamp); end
    checks++;
    if (board_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", board_sel); end
    checks++;
    if ({emerg_busy, emerg_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_emerg got %b want 00", {emerg_busy, emerg_ack});
    end
    reset_dut(4'b0000);
    // No requests: stays all-red indefinitely.
    repeat (20) @(negedge clk);
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL idle_lamp got %h want 00", lamp); end
  endtask

  task automatic test_single();
    logic [7:0] vals [5];
    int         cnts [5];
    vals = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
    cnts = '{1, 32, 4, 2, 1};
    reset_dut(4'b0001);
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL single_c0 got %h want 00", lamp); end
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < cnts[s]; k++) begin
        @(negedge clk);
        checks++;
        if (lamp !== vals[s]) begin
          errors++; $display("FAIL single_seg%0d_%0d got %h want %h", s, k, lamp, vals[s]);
        end
      end
    end
  endtask

  task automatic test_two();
    logic [7:0] vals [5];
    int         cnts [5];
    vals = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h08};
    cnts = '{1, 8, 4, 2, 1};
    reset_dut(4'b0011);
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < cnts[s]; k++) begin
        @(negedge clk);
        checks++;
        if (lamp !== vals[s]) begin
          errors++; $display("FAIL two_seg%0d_%0d got %h want %h", s, k, lamp, vals[s]);
        end
      end
    end
    checks++;
    if (board_sel !== 2'd1) begin errors++; $display("FAIL two_sel got %0d want 1", board_sel); end
  endtask

  task automatic test_wrap();
    logic [7:0] vals [4];
    int         cnts [4];
    vals = '{8'h80, 8'h40, 8'h00, 8'h02};
    cnts = '{7, 4, 2, 1};
    reset_dut(4'b1000);
    repeat (2) @(negedge clk);
    checks++;
    if (lamp !== 8'h80) begin errors++; $display("FAIL wrap_g3 got %h want 80", lamp); end
    req = 4'b1001;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < cnts[s]; k++) begin
        @(negedge clk);
        checks++;
        if (lamp !== vals[s]) begin
          errors++; $display("FAIL wrap_seg%0d_%0d got %h want %h", s, k, lamp, vals[s]);
        end
      end
    end
    checks++;
    if (board_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel got %0d want 0", board_sel); end
  endtask

  task automatic test_reset_mid_yellow();
    bit found = 1'b0;
    reset_dut(4'b0010);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (lamp === 8'h04) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midy_reach got %h want 04", lamp); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL midy_async got %h want 00", lamp); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL midy_ar0 got %h want 00", lamp); end
    @(negedge clk);
    checks++;
    if (lamp !== 8'h00) begin errors++; $display("FAIL midy_ar1 got %h want 00", lamp); end
    @(negedge clk);
    checks++;
    if (lamp !== 8'h08) begin errors++; $display("FAIL midy_green got %h want 08", lamp); end
  endtask

`ifdef TRAFFIC_PHASE_SCHED_EMERG_EN
  task automatic test_preempt();
    reset_dut(4'b0001);
    repeat (3) @(negedge clk);
    checks++;
    if (lamp !== 8'h02) begin errors++; $display("FAIL pre_g1 got %h want 02", lamp); end
    emerg_valid = 1'b1;
    emerg_board = 2'd2;
    @(negedge clk);
    checks++;
    if (lamp !== 8'h02 || emerg_busy !== 1'b1) begin
      errors++; $display("FAIL pre_latch got lamp=%h busy=%b want 02/1", lamp, emerg_busy);
    end
    emerg_board = 2'd3;  // must be dropped while busy
    @(negedge clk);
    emerg_valid = 1'b0;
    checks++;
    if (lamp !== 8'h01) begin errors++; $display("FAIL pre_yel got %h want 01", lamp); end
    repeat (3) @(negedge clk);
    checks++;
    if (lamp !== 8'h01) begin errors++; $display("FAIL pre_yel4 got %h want 01", lamp); end
    repeat (2) @(negedge clk);
    checks++;
    if (lamp !== 8'h00 || emerg_ack !== 1'b0) begin
      errors++; $display("FAIL pre_ar got lamp=%h ack=%b want 00/0", lamp, emerg_ack);
    end
    @(negedge clk);
    checks++;
    if (lamp !== 8'h20 || emerg_ack !== 1'b1 || emerg_busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_serve got lamp=%h ack=%b busy=%b want 20/1/0", lamp, emerg_ack, emerg_busy);
    end
    @(negedge clk);
    checks++;
    if (emerg_ack !== 1'b0 || emerg_busy !== 1'b0 || board_sel !== 2'd2) begin
      errors++;
      $display("FAIL pre_after got ack=%b busy=%b sel=%0d want 0/0/2", emerg_ack, emerg_busy,
               board_sel);
    end
  endtask

  task automatic test_same_board();
    int green = 0;
    reset_dut(4'b0010);
    repeat (7) @(negedge clk);
    checks++;
    if (lamp !== 8'h08) begin errors++; $display("FAIL same_g5 got %h want 08", lamp); end
    emerg_valid = 1'b1;
    emerg_board = 2'd1;
    @(negedge clk);
    emerg_valid = 1'b0;
    checks++;
    if (emerg_ack !== 1'b1 || emerg_busy !== 1'b0 || lamp !== 8'h08) begin
      errors++;
      $display("FAIL same_ack got ack=%b busy=%b lamp=%h want 1/0/08", emerg_ack, emerg_busy, lamp);
    end
    green = 7;
    for (int i = 0; i < 60 && lamp === 8'h08; i++) begin
      @(negedge clk);
      if (lamp === 8'h08) green++;
    end
    checks++;
    if (green != 38) begin errors++; $display("FAIL same_len got %0d want 38", green); end
    checks++;
    if (lamp !== 8'h04) begin errors++; $display("FAIL same_yel got %h want 04", lamp); end
  endtask
`else
  task automatic test_emerg_disabled();
    reset_dut(4'b0001);
    repeat (3) @(negedge clk);
    emerg_valid = 1'b1;
    emerg_board = 2'd2;
    @(negedge clk);
    emerg_valid = 1'b0;
    checks++;
    if ({emerg_busy, emerg_ack} !== 2'b00) begin
      errors++; $display("FAIL dis_flags got %b want 00", {emerg_busy, emerg_ack});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (lamp !== 8'h02 || emerg_ack !== 1'b0) begin
      errors++; $display("FAIL dis_green got lamp=%h ack=%b want 02/0", lamp, emerg_ack);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two();
    test_wrap();
    test_reset_mid_yellow();
`ifdef TRAFFIC_PHASE_SCHED_EMERG_EN
    test_preempt();
    test_same_board();
`else
    test_emerg_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
